// File: rtl/keypad_pkg.sv
// Shared types and key-map decode for the keypad scanner.
// State enum, 4-bit key code type, bit-index and key-map helpers.
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        HELD,
        RELEASE
    } state_t;

    typedef logic [3:0] key_t;

    // Index of the lowest set bit; 3 when only bit 3 (or nothing) is set.
    function automatic logic [1:0] lsb_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        if (v[2]) idx = 2'd2;
        if (v[1]) idx = 2'd1;
        if (v[0]) idx = 2'd0;
        return idx;
    endfunction

    // Row/column position to printed key legend.
    function automatic key_t key_decode(input logic [1:0] r,
                                        input logic [1:0] c);
        key_t k;
        k = 4'h0;
        unique case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            4'hF: k = 4'hD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad matrix and key-event bundle.
// master: scanner (drives row, key outputs); slave: matrix/consumer side.
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic [3:0] col;
    logic [3:0] row;
    key_t       key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col,
        output row, key_code, key_valid, key_held
    );

    modport slave (
        output col,
        input  row, key_code, key_valid, key_held
    );

endinterface

// File: rtl/keypad_debounce_cnt.sv
// Saturating up-counter with synchronous clear and terminal flag.
// Ports: clk, reset, clr_i (priority), en_i, done_o (count == MAX).
module keypad_debounce_cnt #(
    parameter int unsigned MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != MAX_V))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == MAX_V);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row rotation, press/release debounce, one event per key.
// Ports: clk, reset (async, active-high), kp (master: col in; row/key out).
// Optional macro KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 48000,
    parameter int unsigned DEBOUNCE_CYCLES = 960000,
    parameter int unsigned REPEAT_CYCLES   = 24000000
) (
    input  logic clk,
    input  logic reset,
    keypad_scan_ctrl_if.master kp
);

    state_t     state_q, state_d;
    logic [3:0] row_q, row_d;
    logic [1:0] rsel_q, rsel_d;
    logic [1:0] csel_q, csel_d;
    key_t       code_q, code_d;
    logic       valid, held, hit;

    logic dwell_clr, dwell_en, dwell_done;
    logic db_clr, db_en, db_done;

    // Only the latched column matters once a key is locked in.
    assign hit = kp.col[csel_q];

    keypad_debounce_cnt #(.MAX(SCAN_CYCLES - 1)) u_dwell (
        .clk(clk), .reset(reset),
        .clr_i(dwell_clr), .en_i(dwell_en), .done_o(dwell_done)
    );

    // Terminal at DEBOUNCE_CYCLES, so the exit edge is one past the
    // window: press-to-pulse latency is DEBOUNCE_CYCLES+1.
    keypad_debounce_cnt #(.MAX(DEBOUNCE_CYCLES)) u_db (
        .clk(clk), .reset(reset),
        .clr_i(db_clr), .en_i(db_en), .done_o(db_done)
    );

`ifdef KEYPAD_REPEAT_EN
    logic rep_clr, rep_en, rep_done;

    keypad_debounce_cnt #(.MAX(REPEAT_CYCLES - 1)) u_rep (
        .clk(clk), .reset(reset),
        .clr_i(rep_clr), .en_i(rep_en), .done_o(rep_done)
    );
`else
    // Repeat interval has no meaning without auto-repeat.
    logic unused_rep;
    assign unused_rep = ^REPEAT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        rsel_d    = rsel_q;
        csel_d    = csel_q;
        code_d    = code_q;
        dwell_clr = 1'b1;
        dwell_en  = 1'b0;
        db_clr    = 1'b1;
        db_en     = 1'b0;
        valid     = 1'b0;
        held      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_clr   = 1'b1;
        rep_en    = 1'b0;
`endif
        unique case (state_q)
            SCAN: begin
                dwell_clr = 1'b0;
                dwell_en  = 1'b1;
                if (kp.col != 4'b0000) begin
                    rsel_d    = lsb_idx(row_q);
                    csel_d    = lsb_idx(kp.col);
                    dwell_clr = 1'b1;
                    state_d   = DEBOUNCE;
                end else if (dwell_done) begin
                    row_d     = {row_q[2:0], row_q[3]};
                    dwell_clr = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!hit) begin
                    state_d = SCAN;
                end else if (db_done) begin
                    code_d  = key_decode(rsel_q, csel_q);
                    state_d = EMIT;
                end else begin
                    db_clr = 1'b0;
                    db_en  = 1'b1;
                end
            end
            EMIT: begin
                valid   = 1'b1;
                held    = 1'b1;
                state_d = HELD;
            end
            HELD: begin
                held = 1'b1;
                if (!hit) begin
                    state_d = RELEASE;
`ifdef KEYPAD_REPEAT_EN
                end else begin
                    rep_clr = rep_done;
                    rep_en  = 1'b1;
                    valid   = rep_done;
`endif
                end
            end
            RELEASE: begin
                held = 1'b1;
                if (hit) begin
                    state_d = HELD;
                end else if (db_done) begin
                    row_d   = 4'b0001;
                    state_d = SCAN;
                end else begin
                    db_clr = 1'b0;
                    db_en  = 1'b1;
                end
            end
            default: begin
                row_d   = 4'b0001;
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SCAN;
            row_q   <= 4'b0001;
            rsel_q  <= 2'd0;
            csel_q  <= 2'd0;
            code_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rsel_q  <= rsel_d;
            csel_q  <= csel_d;
            code_q  <= code_d;
        end
    end

    assign kp.row       = row_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid;
    assign kp.key_held  = held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with a 4x4 switch-matrix model.
// Expected key events are queued by stimulus and popped by the monitor.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    localparam int S = 4;
    localparam int D = 8;
    localparam int R = 16;

    logic clk = 1'b0;
    logic reset;

    keypad_scan_ctrl_if kp();

    keypad_scan_ctrl #(
        .SCAN_CYCLES(S),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kp(kp.master)
    );

    always #5 clk = ~clk;

    // keys[r][c] = 1 means the switch at row r, column c is closed.
    logic [3:0] keys [4];

    always_comb begin
        kp.col = 4'b0000;
        for (int r = 0; r < 4; r++)
            if (kp.row[r]) kp.col = kp.col | keys[r];
    end

    typedef struct {
        key_t code;
        int   at;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && kp.key_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got code %0h expected none",
                         kp.key_code);
            end else begin
                e = sb.pop_front();
                chk("pulse_code", kp.key_code, e.code);
                if (e.at >= 0) chk("pulse_latency", cyc, e.at);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns 1 ns after the first negedge where col is nonzero.
    task automatic wait_col(output int c);
        int k;
        k = 0;
        #1;
        while (kp.col == 4'b0000 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL col_timeout: got col 0 expected nonzero");
        end
        c = cyc;
    endtask

    task automatic wait_pulse(input int target, input string name);
        int k;
        k = 0;
        while (pulses < target && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(name, pulses, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c, n, p;
        reset = 1'b1;
        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_row", kp.row, 4'b0001);
        chk("rst_code", kp.key_code, 4'h0);
        chk("rst_valid", kp.key_valid, 1'b0);
        chk("rst_held", kp.key_held, 1'b0);

        // Steady press r1/c2, latency and release tail.
        keys[1][2] = 1'b1;
        wait_col(c);
        sb.push_back('{4'h6, c + D + 2});
        wait_pulse(1, "t1_pulse");
        tick(3);
        chk("t1_held", kp.key_held, 1'b1);
        keys[1][2] = 1'b0;
        n = cyc;
        tick(9);
        chk("t1_held_tail", kp.key_held, 1'b1);
        tick(1);
        chk("t1_held_off", kp.key_held, 1'b0);
        chk("t1_row_home", kp.row, 4'b0001);
        chk("t1_code_hold", kp.key_code, 4'h6);

        // Press bounce: 3 high samples, then scanning resumes at r1.
        keys[1][2] = 1'b1;
        wait_col(c);
        chk("t2_row_frozen", kp.row, 4'b0010);
        tick(3);
        keys[1][2] = 1'b0;
        tick(1);
        chk("t2_row_resume", kp.row, 4'b0010);
        tick(3);
        chk("t2_row_dwell", kp.row, 4'b0010);
        tick(1);
        chk("t2_row_next", kp.row, 4'b0100);
        tick(20);
        chk("t2_no_pulse", pulses, 1);

        // Lockout: r0/c0 held, r2/c1 added, then r2/c1 after release.
        keys[0][0] = 1'b1;
        wait_col(c);
        sb.push_back('{4'h1, c + D + 2});
        wait_pulse(2, "t3_pulse1");
        keys[2][1] = 1'b1;
        tick(5);
        chk("t3_row_locked", kp.row, 4'b0001);
        chk("t3_held", kp.key_held, 1'b1);
        sb.push_back('{4'h8, -1});
        keys[0][0] = 1'b0;
        wait_pulse(3, "t3_pulse2");
        keys[2][1] = 1'b0;
        tick(12);
        chk("t3_released", kp.key_held, 1'b0);

        // Release bounce on r3/c1 (code 0).
        keys[3][1] = 1'b1;
        wait_col(c);
        sb.push_back('{4'h0, -1});
        wait_pulse(4, "t4_pulse");
        for (int i = 0; i < 4; i++) begin
            keys[3][1] = 1'b0;
            tick(3);
            chk("t4_held_lo", kp.key_held, 1'b1);
            keys[3][1] = 1'b1;
            tick(3);
            chk("t4_held_hi", kp.key_held, 1'b1);
        end
        keys[3][1] = 1'b0;
        tick(12);
        chk("t4_released", kp.key_held, 1'b0);
        chk("t4_one_pulse", pulses, 4);
        chk("t4_code", kp.key_code, 4'h0);

        // Reset 4 cycles into debounce aborts the pending event.
        keys[0][3] = 1'b1;
        wait_col(c);
        tick(4);
        reset = 1'b1;
        #1;
        chk("t5_rst_row", kp.row, 4'b0001);
        chk("t5_rst_code", kp.key_code, 4'h0);
        chk("t5_rst_held", kp.key_held, 1'b0);
        keys[0][3] = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("t5_row_after", kp.row, 4'b0001);
        chk("t5_code_after", kp.key_code, 4'h0);
        tick(20);
        chk("t5_no_pulse", pulses, 4);

        // Long hold of r3/c3 (code D).
        keys[3][3] = 1'b1;
        wait_col(c);
        sb.push_back('{4'hD, c + D + 2});
`ifdef KEYPAD_REPEAT_EN
        for (int i = 0; i < 3; i++) sb.push_back('{4'hD, -1});
        p = 8;
`else
        p = 5;
`endif
        wait_pulse(5, "t6_pulse");
        tick(50);
        keys[3][3] = 1'b0;
        tick(15);
        chk("t6_pulse_total", pulses, p);
        chk("t6_held_off", kp.key_held, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_CYCLES, default 48000: cycles each row is driven during scanning (1 ms at 48 MHz).
REQ-002 Parameter DEBOUNCE_CYCLES, default 960000: press and release debounce window (20 ms).
REQ-003 Parameter REPEAT_CYCLES, default 24000000: auto-repeat interval (0.5 s); used only when KEYPAD_REPEAT_EN is defined.
REQ-004 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 col  input  4  synchronized column sense, active-high (1 = key closed in the driven row).
REQ-007 row  output  4  one-hot row drive, active-high.
REQ-008 key_code  output  4  hex code of the last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse when key_code is newly accepted.
REQ-010 key_held  output  1  high while the accepted key is held, including release debounce.

Function
REQ-011 FSM states SHALL be SCAN, DEBOUNCE, EMIT, HELD and RELEASE.
REQ-012 SCAN: row SHALL rotate 0001->0010->0100->1000->0001, advancing every SCAN_CYCLES cycles.
REQ-013 SCAN with col != 0: latch row and the lowest-index set col bit, freeze row, clear counter, go to DEBOUNCE.
REQ-014 DEBOUNCE with latched col bit low: return to SCAN with no event; scanning resumes at the frozen row with its dwell counter cleared.
REQ-015 DEBOUNCE: after DEBOUNCE_CYCLES consecutive cycles with the latched bit high, go to EMIT.
REQ-016 EMIT lasts one cycle: key_valid=1, key_code updated in the same cycle; then go to HELD.
REQ-017 Total latency: key_valid SHALL assert exactly DEBOUNCE_CYCLES+1 cycles after the SCAN edge that samples the press.
REQ-018 HELD: stay while the latched bit is high; all other columns and rows are ignored (single-key lockout).
REQ-019 HELD with latched bit low: clear counter, go to RELEASE.
REQ-020 RELEASE with latched bit high again: return to HELD with no new event.
REQ-021 RELEASE: after DEBOUNCE_CYCLES consecutive low cycles, go to SCAN, row=0001, key_held=0.
REQ-022 Key map (row index, col index 0..3): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-023 key_code SHALL hold its value between events; it changes only in EMIT.
REQ-024 Counters SHALL be wide enough for the largest parameter and SHALL never wrap within a state.

Reset
REQ-025 Reset SHALL force state=SCAN, row=0001, key_code=0, key_valid=0, key_held=0 and all counters to 0.
REQ-026 Reset asserted in any state SHALL abort any pending event; no key_valid pulse may follow deassertion unless a new press is debounced.

Configuration
REQ-027 Macro KEYPAD_REPEAT_EN defined: in HELD, each REPEAT_CYCLES consecutive held cycles SHALL emit one key_valid pulse with the same key_code, then restart the repeat count.
REQ-028 Macro KEYPAD_REPEAT_EN undefined: exactly one key_valid pulse per debounced press, and the repeat counter is not synthesized.

Structure
REQ-029 Package keypad_pkg SHALL hold the state enum, the 4-bit key_t type and the key-map decode function.
REQ-030 Sub-module keypad_debounce_cnt (a parameterized saturating counter with clear and terminal flag) SHALL serve the dwell, debounce and repeat counts.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=16)
REQ-031 Steady press r1/c2 -> key_code=6, single key_valid exactly 9 cycles after sampling, key_held=1 until release plus 8 cycles.
REQ-032 Press bounce: col high 3 cycles then low -> no key_valid, row resumes rotation from the frozen row.
REQ-033 Hold r0/c0, then add r2/c1 -> one pulse with code 1 only; after release and debounce, r2/c1 still held -> pulse with code 8.
REQ-034 Release bounce: toggle the latched col every 3 cycles during RELEASE -> no second pulse, key_held stays 1.
REQ-035 Reset pulsed 4 cycles into DEBOUNCE -> no key_valid; row=0001 and key_code=0 immediately after reset.
REQ-036 KEYPAD_REPEAT_EN defined, hold r3/c3 for 50 cycles after EMIT -> 3 further pulses, each with key_code=D; macro undefined -> exactly 1 pulse total.
